fetch_sequencer: RTL

Instruction-fetch controller for the RISC-V core. It owns the fetch PC and chooses the next PC from sequential, branch, jump and trap sources. It runs the request/acknowledge handshake with instruction memory and delivers fetched instructions to decode through a one-entry output register held by the pipeline stall. It sits between the program counter datapath, the instruction memory port and the IF/ID boundary.

---
 rtl/fetch_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer
// Instruction-fetch controller: owns the fetch PC, runs the imem req/ack
// handshake and feeds decode through a one-entry output register.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (misaligned jump/branch traps).
// Revision: 1.0
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          MAX_WAIT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        trap_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc_4,
    output logic        flush,
    output logic        fetch_error
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [31:0] held_addr, held_addr_nx;
    logic        kill, kill_nx;
    logic [3:0]  wait_cnt, wait_cnt_nx;
    logic        inst_valid_nx;
    logic [31:0] inst_nx, inst_pc_nx;
    logic        fetch_error_nx;
    logic        redirect, misalign;
    logic [31:0] raw_target, target;

    always_comb begin
        redirect = trap_valid | jump_valid | branch_taken;
        if (trap_valid)
            raw_target = TRAP_VECTOR;
        else if (jump_valid)
            raw_target = jump_target;
        else
            raw_target = branch_target;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign = !trap_valid && (jump_valid || branch_taken) && (raw_target[1:0] != 2'b00);
        target   = misalign ? TRAP_VECTOR : raw_target;
`else
        misalign = 1'b0;
        target   = raw_target & 32'hFFFF_FFFC;
`endif
    end

    assign flush     = redirect;
    assign imem_req  = (state == FETCH);
    // While a killed request is outstanding the old address must stay on the bus.
    assign imem_addr = kill ? held_addr : fetch_pc;
    assign inst_pc_4 = inst_pc + 32'd4;

    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        held_addr_nx   = held_addr;
        kill_nx        = kill;
        wait_cnt_nx    = 4'd0;
        inst_valid_nx  = inst_valid;
        inst_nx        = inst;
        inst_pc_nx     = inst_pc;
        fetch_error_nx = 1'b0;

        if (inst_valid && !stall)
            inst_valid_nx = 1'b0;

        case (state)
            BOOT: state_nx = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (kill) begin
                        kill_nx = 1'b0;
                    end else if (!redirect) begin
                        inst_nx       = imem_rdata;
                        inst_pc_nx    = fetch_pc;
                        inst_valid_nx = 1'b1;
                        fetch_pc_nx   = fetch_pc + 32'd4;
                        state_nx      = stall ? HOLD : FETCH;
                    end
                end else begin
                    wait_cnt_nx = wait_cnt + 4'd1;
                    if (wait_cnt == WAIT_LIMIT && !redirect) begin
                        fetch_pc_nx    = TRAP_VECTOR;
                        inst_valid_nx  = 1'b0;
                        kill_nx        = 1'b0;
                        fetch_error_nx = 1'b1;
                        wait_cnt_nx    = 4'd0;
                        state_nx       = BOOT;
                    end
                end
            end
            HOLD: begin
                if (!stall || redirect)
                    state_nx = FETCH;
            end
            default: state_nx = BOOT;
        endcase

        if (redirect) begin
            fetch_pc_nx    = target;
            inst_valid_nx  = 1'b0;
            fetch_error_nx = misalign;
            if (state == FETCH && !imem_ack && !kill) begin
                kill_nx      = 1'b1;
                held_addr_nx = fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_VECTOR;
            held_addr   <= RESET_VECTOR;
            kill        <= 1'b0;
            wait_cnt    <= 4'd0;
            inst_valid  <= 1'b0;
            inst        <= 32'd0;
            inst_pc     <= 32'd0;
            fetch_error <= 1'b0;
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            held_addr   <= held_addr_nx;
            kill        <= kill_nx;
            wait_cnt    <= wait_cnt_nx;
            inst_valid  <= inst_valid_nx;
            inst        <= inst_nx;
            inst_pc     <= inst_pc_nx;
            fetch_error <= fetch_error_nx;
        end
    end

endmodule
`default_nettype wire
